// File: rtl/dom_mask_prng_pkg.sv
// Shared definitions for the fresh-mask PRNG: xorshift32 step, zero-seed
// substitute, FSM encoding and the randomness width helpers.
package dom_mask_prng_pkg;

  // Substituted for an all-zero seed word, since xorshift32 is stuck at zero.
  localparam logic [31:0] ZERO_SEED_SUB = 32'h6A09E667;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    SEEDING  = 2'd1,
    WARMUP   = 2'd2,
    RUN      = 2'd3
  } prngState_t;

  function automatic logic [31:0] xorshift32Step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic int rndWidth(input int shares, input int blindW);
    return 3 * shares * (shares - 1) + blindW;
  endfunction

  function automatic int laneCount(input int rndW);
    return (rndW + 31) / 32;
  endfunction

endpackage

// File: rtl/dom_mask_prng_xorshift32_lane.sv
// One 32-bit xorshift32 lane; only the low OUT_W bits are exposed to the top.
module xorshift32_lane
  import dom_mask_prng_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             ClkxCI,
  input  logic             RstxBI,
  input  logic             clearxSI,
  input  logic             loadxSI,
  input  logic [31:0]      loadValxDI,
  input  logic             stepxSI,
  output logic [OUT_W-1:0] valuexDO
);

  logic [31:0] laneState;

  // Clear wins over load, load wins over step.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      laneState <= '0;
    end else if (clearxSI) begin
      laneState <= '0;
    end else if (loadxSI) begin
      laneState <= loadValxDI;
    end else if (stepxSI) begin
      laneState <= xorshift32Step(laneState);
    end
  end

  assign valuexDO = laneState[OUT_W-1:0];

endmodule

// File: rtl/dom_mask_prng.sv
// Fresh-randomness source for the masked S-box: seeded xorshift32 lanes split
// into the _Zmul1/2/3 remask buses and the _Bmul blinding bus.
module dom_mask_prng
  import dom_mask_prng_pkg::*;
#(
  parameter int SHARES       = 2,
  parameter int BLIND_W      = 6,
  parameter int WARMUP_STEPS = 16
) (
  input  logic                         ClkxCI,
  input  logic                         RstxBI,
  input  logic [31:0]                  SeedxDI,
  input  logic                         SeedValidxSI,
  output logic                         SeedReadyxSO,
  input  logic                         ReseedxSI,
  input  logic                         EnxSI,
  output logic                         RndValidxSO,
  output logic [SHARES*(SHARES-1)-1:0] _Zmul1xDO,
  output logic [SHARES*(SHARES-1)-1:0] _Zmul2xDO,
  output logic [SHARES*(SHARES-1)-1:0] _Zmul3xDO,
  output logic [BLIND_W-1:0]           _BmulxDO
);

  localparam int ZW    = SHARES * (SHARES - 1);
  localparam int RND_W = rndWidth(SHARES, BLIND_W);
  localparam int NLANE = laneCount(RND_W);
  localparam int IDX_W = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NLANE - 1);
  localparam logic [7:0]       WARM_LAST = 8'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);

  prngState_t       state, stateNext;
  logic [IDX_W-1:0] loadIdx, loadIdxNext;
  logic [7:0]       warmCnt, warmCntNext;

  logic             seedAccept;
  logic             laneStep;
  logic [31:0]      loadWord;
  logic             rndValid;
  logic [RND_W-1:0] rndBits;
  logic [RND_W-1:0] rndOut;

  assign SeedReadyxSO = (state == UNSEEDED) || (state == SEEDING);
  assign seedAccept   = SeedValidxSI && SeedReadyxSO && !ReseedxSI;
  assign laneStep     = !ReseedxSI && ((state == WARMUP) || ((state == RUN) && EnxSI));
  assign loadWord     = (SeedxDI == 32'd0) ? ZERO_SEED_SUB : SeedxDI;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state   <= UNSEEDED;
      loadIdx <= '0;
      warmCnt <= '0;
    end else begin
      state   <= stateNext;
      loadIdx <= loadIdxNext;
      warmCnt <= warmCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    loadIdxNext = loadIdx;
    warmCntNext = warmCnt;
    if (ReseedxSI) begin
      stateNext   = UNSEEDED;
      loadIdxNext = '0;
      warmCntNext = '0;
    end else begin
      unique case (state)
        UNSEEDED, SEEDING: begin
          if (seedAccept) begin
            if (loadIdx == LAST_IDX) begin
              stateNext   = (WARMUP_STEPS == 0) ? RUN : WARMUP;
              loadIdxNext = '0;
            end else begin
              stateNext   = SEEDING;
              loadIdxNext = loadIdx + 1'b1;
            end
          end
        end
        WARMUP: begin
          if (warmCnt == WARM_LAST) begin
            stateNext   = RUN;
            warmCntNext = '0;
          end else begin
            warmCntNext = warmCnt + 8'd1;
          end
        end
        RUN: begin
          stateNext = RUN;
        end
        default: begin
          stateNext = UNSEEDED;
        end
      endcase
    end
  end

  // Each lane contributes only the bits that land inside the RND_W vector.
  for (genvar i = 0; i < NLANE; i++) begin : genLane
    localparam int LANE_OUT_W = ((RND_W - i * 32) >= 32) ? 32 : (RND_W - i * 32);

    logic [LANE_OUT_W-1:0] laneValue;

    xorshift32_lane #(
      .OUT_W(LANE_OUT_W)
    ) uLane (
      .ClkxCI    (ClkxCI),
      .RstxBI    (RstxBI),
      .clearxSI  (ReseedxSI),
      .loadxSI   (seedAccept && (loadIdx == IDX_W'(i))),
      .loadValxDI(loadWord),
      .stepxSI   (laneStep),
      .valuexDO  (laneValue)
    );

    assign rndBits[i*32 +: LANE_OUT_W] = laneValue;
  end

  assign rndValid    = (state == RUN);
  assign RndValidxSO = rndValid;
  assign rndOut      = rndValid ? rndBits : '0;

  assign _Zmul1xDO = rndOut[ZW-1:0];
  assign _Zmul2xDO = rndOut[2*ZW-1:ZW];
  assign _Zmul3xDO = rndOut[3*ZW-1:2*ZW];
  assign _BmulxDO  = rndOut[RND_W-1:3*ZW];

endmodule

// File: tb/tb_dom_mask_prng.sv
// Directed bench for dom_mask_prng: three configurations share one clock and
// reset; expected vectors are hand-computed or from a local xorshift32 model.
module tb_dom_mask_prng;

  logic clk;
  logic rstN;

  int checks = 0;
  int errors = 0;

  // Instance A: SHARES=2, BLIND_W=6, no warm-up
  logic [31:0] seedA;
  logic        validA, readyA, reseedA, enA, rndValidA;
  logic [1:0]  z1A, z2A, z3A;
  logic [5:0]  bA;

  // Instance B: SHARES=2, BLIND_W=6, 16 warm-up steps
  logic [31:0] seedB;
  logic        validB, readyB, reseedB, enB, rndValidB;
  logic [1:0]  z1B, z2B, z3B;
  logic [5:0]  bB;

  // Instance C: SHARES=3, BLIND_W=20, two lanes, no warm-up
  logic [31:0] seedC;
  logic        validC, readyC, reseedC, enC, rndValidC;
  logic [5:0]  z1C, z2C, z3C;
  logic [19:0] bC;

  logic [31:0] modelX;
  logic [31:0] modelL0;
  logic [31:0] modelL1;
  logic [37:0] expC;

  dom_mask_prng #(.SHARES(2), .BLIND_W(6), .WARMUP_STEPS(0)) dutA (
    .ClkxCI(clk), .RstxBI(rstN), .SeedxDI(seedA), .SeedValidxSI(validA),
    .SeedReadyxSO(readyA), .ReseedxSI(reseedA), .EnxSI(enA),
    .RndValidxSO(rndValidA), ._Zmul1xDO(z1A), ._Zmul2xDO(z2A),
    ._Zmul3xDO(z3A), ._BmulxDO(bA)
  );

  dom_mask_prng #(.SHARES(2), .BLIND_W(6), .WARMUP_STEPS(16)) dutB (
    .ClkxCI(clk), .RstxBI(rstN), .SeedxDI(seedB), .SeedValidxSI(validB),
    .SeedReadyxSO(readyB), .ReseedxSI(reseedB), .EnxSI(enB),
    .RndValidxSO(rndValidB), ._Zmul1xDO(z1B), ._Zmul2xDO(z2B),
    ._Zmul3xDO(z3B), ._BmulxDO(bB)
  );

  dom_mask_prng #(.SHARES(3), .BLIND_W(20), .WARMUP_STEPS(0)) dutC (
    .ClkxCI(clk), .RstxBI(rstN), .SeedxDI(seedC), .SeedValidxSI(validC),
    .SeedReadyxSO(readyC), .ReseedxSI(reseedC), .EnxSI(enC),
    .RndValidxSO(rndValidC), ._Zmul1xDO(z1C), ._Zmul2xDO(z2C),
    ._Zmul3xDO(z3C), ._BmulxDO(bC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refStep(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstN = 1'b0;
    seedA = '0; validA = 1'b0; reseedA = 1'b0; enA = 1'b0;
    seedB = '0; validB = 1'b0; reseedB = 1'b0; enB = 1'b0;
    seedC = '0; validC = 1'b0; reseedC = 1'b0; enC = 1'b0;

    // Reset values
    applyStimulus(1);
    checkOutput("rstA_valid", 64'(rndValidA), 64'd0);
    checkOutput("rstA_ready", 64'(readyA), 64'd1);
    checkOutput("rstA_bus", 64'({bA, z3A, z2A, z1A}), 64'd0);
    checkOutput("rstC_bus", 64'({bC, z3C, z2C, z1C}), 64'd0);
    checkOutput("rstB_ready", 64'(readyB), 64'd1);
    rstN = 1'b1;

    // A: seed 1, valid the next cycle
    applyStimulus(1);
    seedA = 32'h00000001; validA = 1'b1;
    applyStimulus(1);
    validA = 1'b0;
    checkOutput("A_seed1_valid", 64'(rndValidA), 64'd1);
    checkOutput("A_seed1_ready", 64'(readyA), 64'd0);
    checkOutput("A_seed1_z1", 64'(z1A), 64'h1);
    checkOutput("A_seed1_z2", 64'(z2A), 64'h0);
    checkOutput("A_seed1_z3", 64'(z3A), 64'h0);
    checkOutput("A_seed1_bmul", 64'(bA), 64'h0);

    // A: one enable pulse -> lane 0x00042021
    enA = 1'b1;
    applyStimulus(1);
    enA = 1'b0;
    checkOutput("A_step1_low12", 64'({bA, z3A, z2A, z1A}), 64'h021);
    checkOutput("A_step1_z3", 64'(z3A), 64'h2);
    applyStimulus(2);
    checkOutput("A_hold", 64'({bA, z3A, z2A, z1A}), 64'h021);

    // A: seed words offered in RUN are ignored
    seedA = 32'hFFFFFFFF; validA = 1'b1;
    applyStimulus(1);
    validA = 1'b0;
    checkOutput("A_run_seed_ignored", 64'({bA, z3A, z2A, z1A}), 64'h021);

    // A: reseed together with enable
    reseedA = 1'b1; enA = 1'b1;
    applyStimulus(1);
    reseedA = 1'b0; enA = 1'b0;
    checkOutput("A_reseed_valid", 64'(rndValidA), 64'd0);
    checkOutput("A_reseed_ready", 64'(readyA), 64'd1);
    checkOutput("A_reseed_bus", 64'({bA, z3A, z2A, z1A}), 64'd0);

    // A: zero seed -> 0x6A09E667
    seedA = 32'h00000000; validA = 1'b1;
    applyStimulus(1);
    validA = 1'b0;
    checkOutput("A_zero_valid", 64'(rndValidA), 64'd1);
    checkOutput("A_zero_low12", 64'({bA, z3A, z2A, z1A}), 64'h667);
    checkOutput("A_zero_bmul", 64'(bA), 64'h19);

    // B: 16-cycle warm-up
    seedB = 32'h00000001; validB = 1'b1;
    applyStimulus(1);
    validB = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("B_warm_valid_%0d", k), 64'(rndValidB), 64'd0);
      checkOutput($sformatf("B_warm_bus_%0d", k), 64'({bB, z3B, z2B, z1B}), 64'd0);
      applyStimulus(1);
    end
    modelX = 32'h00000001;
    repeat (16) modelX = refStep(modelX);
    checkOutput("B_run_valid", 64'(rndValidB), 64'd1);
    checkOutput("B_run_vector", 64'({bB, z3B, z2B, z1B}), 64'(modelX[11:0]));

    // C: two lanes seeded with a gap between words
    seedC = 32'h12345678; validC = 1'b1;
    applyStimulus(1);
    validC = 1'b0; seedC = 32'hDEADBEEF;
    checkOutput("C_gap_ready", 64'(readyC), 64'd1);
    checkOutput("C_gap_valid", 64'(rndValidC), 64'd0);
    applyStimulus(1);
    seedC = 32'h0000002B; validC = 1'b1;
    applyStimulus(1);
    validC = 1'b0;
    checkOutput("C_seeded_valid", 64'(rndValidC), 64'd1);
    checkOutput("C_seeded_ready", 64'(readyC), 64'd0);
    checkOutput("C_z1", 64'(z1C), 64'h38);
    checkOutput("C_z2", 64'(z2C), 64'h19);
    checkOutput("C_z3", 64'(z3C), 64'h05);
    checkOutput("C_bmul", 64'(bC), 64'hAC48D);

    enC = 1'b1;
    applyStimulus(1);
    enC = 1'b0;
    modelL0 = refStep(32'h12345678);
    modelL1 = refStep(32'h0000002B);
    expC = {modelL1[5:0], modelL0};
    checkOutput("C_step_vector", 64'({bC, z3C, z2C, z1C}), 64'(expC));

    // B: reseed, reseed again, then async reset mid-warm-up
    reseedB = 1'b1;
    applyStimulus(1);
    reseedB = 1'b0;
    seedB = 32'h00000005; validB = 1'b1;
    applyStimulus(1);
    validB = 1'b0;
    checkOutput("B_reseed_warm_ready", 64'(readyB), 64'd0);
    applyStimulus(3);
    #2 rstN = 1'b0;
    #1;
    checkOutput("B_rst_ready", 64'(readyB), 64'd1);
    checkOutput("B_rst_valid", 64'(rndValidB), 64'd0);
    checkOutput("B_rst_bus", 64'({bB, z3B, z2B, z1B}), 64'd0);
    checkOutput("A_rst_valid", 64'(rndValidA), 64'd0);
    applyStimulus(1);
    rstN = 1'b1;
    applyStimulus(2);
    checkOutput("B_after_rst_valid", 64'(rndValidB), 64'd0);
    checkOutput("B_after_rst_ready", 64'(readyB), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dom_mask_prng.md
# dom_mask_prng

Fresh-randomness source for the masked AES S-box datapath. It produces, every enabled cycle, a new vector of uniformly distributed bits split into the `_Zmul1/2/3` remask buses and the `_Bmul` blinding bus. These buses are exactly the fresh-mask inputs consumed by the masked GF(2^4) inverter and the surrounding DOM multipliers. It is seeded through a valid/ready word stream, performs a configurable warm-up, then streams randomness until reseeded or reset.

## Interface
- `SHARES`, default 2, number of shares of the consuming datapath (≥2).
- `BLIND_W`, default 6, width of the blinding bus (`invbcoeff*blind_n_rnd` of the consumer).
- `WARMUP_STEPS`, default 16, number of discarded lane steps after seeding (0..255).
- `ClkxCI`, in, 1, clock.
- `RstxBI`, in, 1: reset. Asynchronous, active-low, on one clock `ClkxCI`.
- `SeedxDI`, in, 32, seed word.
- `SeedValidxSI`, in, 1, seed word valid.
- `SeedReadyxSO`, out, 1, block accepts seed words.
- `ReseedxSI`, in, 1, one-cycle request to discard state and re-enter seeding.
- `EnxSI`, in, 1, consumer takes the current vector; lanes advance.
- `RndValidxSO`, out, 1, output buses carry fresh randomness.
- `_Zmul1xDO`, `_Zmul2xDO`, `_Zmul3xDO`, out, `SHARES*(SHARES-1)` each, remask buses.
- `_BmulxDO`, out, `BLIND_W`, blinding bus.

## Operation
- `RND_W = 3*SHARES*(SHARES-1) + BLIND_W`.
- `NLANE = ceil(RND_W/32)` independent 32-bit xorshift32 lanes.
- Lane step: `x ^= x<<13; x ^= x>>17; x ^= x<<5`.
- Concatenation is {lane NLANE-1 … lane 0}, truncated to the low `RND_W` bits. Bit mapping from the LSB:
  - `_Zmul1` first, then `_Zmul2`, then `_Zmul3`, then `_Bmul`.
- FSM states:
  - **UNSEEDED** (reset state): `SeedReadyxSO`=1. The first accepted word moves the FSM to SEEDING.
  - **SEEDING**: each accepted word (`SeedValidxSI & SeedReadyxSO`) loads the next lane, lane 0 first.
    - A zero word loads constant `0x6A09E667` instead, because the all-zero state is forbidden.
    - After lane NLANE-1 is loaded, go to WARMUP, or directly to RUN if `WARMUP_STEPS`=0.
  - **WARMUP**: all lanes step every cycle. A counter runs to `WARMUP_STEPS`, then the FSM goes to RUN. `RndValidxSO`=0.
  - **RUN**: `RndValidxSO`=1 and the outputs show the lane state. In a cycle with `EnxSI`=1 all lanes step; otherwise the state holds.
- `ReseedxSI`=1 in any state: next state is UNSEEDED, lanes are cleared, and no seed word is accepted in that cycle.
  - Takes priority over `EnxSI` and seed acceptance.
- `SeedReadyxSO`=1 only in UNSEEDED and SEEDING. Words offered in WARMUP or RUN are ignored.
- Output buses are forced to 0 whenever `RndValidxSO`=0. Unmasked state never leaks before RUN.

## Timing
- Reset (async assert, sync deassert by the system):
  - all lanes 0, FSM UNSEEDED, warm-up counter 0;
  - `RndValidxSO`=0, `SeedReadyxSO`=1, all data outputs 0.
- Seeding takes NLANE accepted handshakes. Back-to-back words are accepted one per cycle.
- WARMUP lasts exactly `WARMUP_STEPS` cycles. `RndValidxSO` rises the following cycle.
- Outputs are driven directly from registers: no combinational path from `EnxSI` to the data outputs.
- A new vector appears the cycle after an `EnxSI`=1 cycle.
- Reset asserted mid-seed, mid-warm-up or mid-run returns the block immediately to the reset values above.

## Structure
- Shared package/header holds:
  - the xorshift32 step function;
  - the zero-seed substitute constant;
  - the FSM state encoding (2 bits);
  - the `RND_W`/`NLANE` width functions, reusable by the S-box top.
- One natural sub-module, `xorshift32_lane`: 32-bit register with synchronous load, step enable and clear. It is instantiated NLANE times via generate.
- The top level holds the FSM, the lane load index, the warm-up counter, the output gating and the bus split.

## Test plan
- Reset, then `SHARES`=2, `BLIND_W`=6, `WARMUP_STEPS`=0, seed `0x00000001` -> `RndValidxSO`=1 next cycle. Buses:
  - `_Zmul1`=2'b01, `_Zmul2`=0, `_Zmul3`=0, `_Bmul`=0.
- Continue the previous scenario with one `EnxSI` pulse -> low 12 bits = `0x021` (lane `0x00042021`). With `EnxSI`=0 afterwards, the value holds.
- Seed `0x00000000` -> lane loads `0x6A09E667`; the first RUN vector's low 12 bits = `0x667`.
- `WARMUP_STEPS`=16:
  - `RndValidxSO` stays 0 for 16 cycles after the last seed word and the outputs read 0.
  - Then the vector equals the reference model after 16 steps.
- `SHARES`=3, `BLIND_W`=20 (`RND_W`=38, 2 lanes) -> requires two seed handshakes. `SeedValidxSI` toggling with gaps still loads lane 0 then lane 1.
- `ReseedxSI` together with `EnxSI` in RUN:
  - next cycle UNSEEDED, `RndValidxSO`=0, outputs 0, `SeedReadyxSO`=1.
  - `RstxBI` low mid-WARMUP gives the same result.
